// File: rtl/drive_mode_ctrl.sv
// drive_mode_ctrl: selects idle/camera/IR mode and produces the registered drive command.
module drive_mode_ctrl #(
  parameter int SPEED_LEVELS = 4,
  parameter int ACQ_CYCLES = 8,
  parameter int LOST_CYCLES = 1000,
  parameter int CMD_TIMEOUT = 5000,
  parameter logic [7:0] CODE_CAM = 8'h0F,
  parameter logic [7:0] CODE_IR = 8'h13,
  parameter logic [7:0] CODE_IDLE = 8'h10,
  parameter logic [7:0] CODE_FWD = 8'h02,
  parameter logic [7:0] CODE_LEFT = 8'h04,
  parameter logic [7:0] CODE_RIGHT = 8'h06,
  parameter logic [7:0] CODE_STOP = 8'h05,
  parameter logic [7:0] CODE_UP = 8'h01,
  parameter logic [7:0] CODE_DOWN = 8'h03
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic [7:0] ir_code,
  input  logic ir_valid,
  input  logic [1:0] cam_dir,
  input  logic [$clog2(SPEED_LEVELS)-1:0] cam_speed,
  input  logic target_seen,
  output logic [1:0] mode,
  output logic [2:0] cam_state,
  output logic [2:0] drive_state,
  output logic [$clog2(SPEED_LEVELS)-1:0] drive_speed,
  output logic mode_chg
);
  localparam int SPEED_W = $clog2(SPEED_LEVELS);
  localparam int AW = $clog2(ACQ_CYCLES + 1);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam int TW = $clog2(CMD_TIMEOUT + 1);
  localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPEED_LEVELS - 1);
  localparam logic [AW-1:0] ACQ_MAX = AW'(ACQ_CYCLES);
  localparam logic [LW-1:0] LOST_MAX = LW'(LOST_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(CMD_TIMEOUT);
  localparam logic [1:0] M_IDLE = 2'b00, M_CAM = 2'b01, M_IR = 2'b10;
  localparam logic [2:0] S_SEARCH = 3'b000, S_ACQUIRE = 3'b001, S_FOLLOW = 3'b010,
                         S_LOST = 3'b011, S_PAUSE = 3'b100;
  localparam logic [2:0] D_STOP = 3'b000, D_LEFT = 3'b001, D_RIGHT = 3'b010, D_FWD = 3'b011;
  logic [1:0] mode_n;
  logic [2:0] cam_n, drv_n, man_st, man_st_n;
  logic [SPEED_W-1:0] spd_n, man_spd, man_spd_n, cam_spd;
  logic [AW-1:0] acq, acq_n;
  logic [LW-1:0] lost, lost_n;
  logic [TW-1:0] tmr, tmr_n;
  logic mode_code, drv_code;
  always_comb begin
    mode_code = ir_valid && (ir_code == CODE_CAM || ir_code == CODE_IR || ir_code == CODE_IDLE);
    drv_code = ir_valid && (ir_code == CODE_FWD || ir_code == CODE_LEFT ||
                            ir_code == CODE_RIGHT || ir_code == CODE_STOP);
    mode_n = !mode_code ? mode : ir_code == CODE_CAM ? M_CAM : ir_code == CODE_IR ? M_IR : M_IDLE;
    cam_spd = cam_speed > SPD_MAX ? SPD_MAX : cam_speed;
    cam_n = cam_state;
    acq_n = acq;
    lost_n = lost;
    // A mode code in the current cycle suppresses target tracking for that cycle.
    if (mode_n != M_CAM) cam_n = S_PAUSE;
    else if (mode != M_CAM) begin
      cam_n = S_SEARCH;
      acq_n = '0;
      lost_n = '0;
    end else if (!mode_code)
      case (cam_state)
        S_SEARCH: if (target_seen) begin
          cam_n = S_ACQUIRE;
          acq_n = AW'(1);
        end
        S_ACQUIRE: if (!target_seen) cam_n = S_SEARCH;
        else begin
          acq_n = acq == ACQ_MAX ? acq : acq + 1'b1;
          cam_n = acq_n == ACQ_MAX ? S_FOLLOW : S_ACQUIRE;
        end
        S_FOLLOW: if (!target_seen) begin
          cam_n = S_LOST;
          lost_n = '0;
        end
        S_LOST: if (target_seen) cam_n = S_FOLLOW;
        else if (lost == LOST_MAX) cam_n = S_SEARCH;
        else lost_n = lost + 1'b1;
        default: cam_n = S_SEARCH;
      endcase
    man_st_n = man_st;
    man_spd_n = man_spd;
    tmr_n = tmr;
    if (mode_n == M_IR && mode != M_IR) begin
      man_st_n = D_STOP;
      man_spd_n = '0;
      tmr_n = '0;
    end else if (mode == M_IR) begin
      tmr_n = drv_code ? '0 : tmr == TMR_MAX ? tmr : tmr + 1'b1;
      man_st_n = drv_code ? (ir_code == CODE_FWD ? D_FWD : ir_code == CODE_LEFT ? D_LEFT :
                             ir_code == CODE_RIGHT ? D_RIGHT : D_STOP) :
                 tmr_n == TMR_MAX ? D_STOP : man_st;
      if (ir_valid && ir_code == CODE_UP && man_spd != SPD_MAX) man_spd_n = man_spd + 1'b1;
      if (ir_valid && ir_code == CODE_DOWN && man_spd != '0) man_spd_n = man_spd - 1'b1;
    end
    drv_n = mode_n == M_IR ? man_st_n : mode_n == M_IDLE ? D_STOP :
            cam_n == S_SEARCH ? D_RIGHT : cam_n != S_FOLLOW ? D_STOP :
            cam_dir == 2'b01 ? D_LEFT : cam_dir == 2'b10 ? D_RIGHT :
            cam_dir == 2'b11 ? D_FWD : D_STOP;
    spd_n = drv_n != D_FWD ? '0 : mode_n == M_IR ? man_spd_n : cam_spd;
  end
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) begin
      mode <= M_IDLE;
      cam_state <= S_PAUSE;
      drive_state <= D_STOP;
      drive_speed <= '0;
      mode_chg <= 1'b0;
      acq <= '0;
      lost <= '0;
      tmr <= '0;
      man_st <= D_STOP;
      man_spd <= '0;
    end else begin
      mode <= mode_n;
      cam_state <= cam_n;
      drive_state <= drv_n;
      drive_speed <= spd_n;
      mode_chg <= mode_n != mode || cam_n != cam_state;
      acq <= acq_n;
      lost <= lost_n;
      tmr <= tmr_n;
      man_st <= man_st_n;
      man_spd <= man_spd_n;
    end
endmodule

// File: tb/tb_drive_mode_ctrl.sv
// tb_drive_mode_ctrl: directed scoreboard bench for drive_mode_ctrl.
module tb_drive_mode_ctrl;
  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] ir_code = '0;
  logic ir_valid = 1'b0;
  logic [1:0] cam_dir = '0;
  logic [1:0] cam_speed = '0;
  logic target_seen = 1'b0;
  logic [1:0] mode;
  logic [2:0] cam_state;
  logic [2:0] drive_state;
  logic [1:0] drive_speed;
  logic mode_chg;
  logic [10:0] sb[$];
  int passed = 0;
  int total = 0;
  int fails = 0;
  drive_mode_ctrl dut (
    .clk_50(clk_50), .reset_n(reset_n), .ir_code(ir_code), .ir_valid(ir_valid),
    .cam_dir(cam_dir), .cam_speed(cam_speed), .target_seen(target_seen), .mode(mode),
    .cam_state(cam_state), .drive_state(drive_state), .drive_speed(drive_speed),
    .mode_chg(mode_chg)
  );
  always #10 clk_50 = ~clk_50;
  function automatic logic [10:0] ex(input logic [1:0] m, input logic [2:0] c,
                                     input logic [2:0] d, input logic [1:0] s, input logic g);
    return {m, c, d, s, g};
  endfunction
  task automatic check(input string tag, input logic [10:0] e);
    logic [10:0] got;
    got = {mode, cam_state, drive_state, drive_speed, mode_chg};
    total++;
    assert (got === e) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h (mode,cam,drv,spd,chg)", tag, got, e);
    end
  endtask
  task automatic tick(input string tag, input logic [10:0] e);
    sb.push_back(e);
    @(posedge clk_50);
    #1;
    check(tag, sb.pop_front());
  endtask
  task automatic ir(input logic [7:0] code, input string tag, input logic [10:0] e);
    ir_valid = 1'b1;
    ir_code = code;
    tick(tag, e);
    ir_valid = 1'b0;
  endtask
  initial begin
    #15;
    check("reset_async", ex(0, 4, 0, 0, 0));
    repeat (2) @(posedge clk_50);
    #1;
    check("reset_held", ex(0, 4, 0, 0, 0));
    reset_n = 1'b1;
    tick("idle", ex(0, 4, 0, 0, 0));
    ir(8'h0F, "cam_on", ex(1, 0, 2, 0, 1));
    tick("cam_chg_clr", ex(1, 0, 2, 0, 0));
    target_seen = 1'b1;
    tick("acq7_enter", ex(1, 1, 0, 0, 1));
    repeat (6) tick("acq7_hold", ex(1, 1, 0, 0, 0));
    target_seen = 1'b0;
    tick("acq7_drop", ex(1, 0, 2, 0, 1));
    tick("search_hold", ex(1, 0, 2, 0, 0));
    target_seen = 1'b1;
    tick("acq8_enter", ex(1, 1, 0, 0, 1));
    repeat (6) tick("acq8_hold", ex(1, 1, 0, 0, 0));
    tick("follow", ex(1, 2, 0, 0, 1));
    cam_dir = 2'b11;
    cam_speed = 2'd3;
    tick("follow_fwd", ex(1, 2, 3, 3, 0));
    cam_dir = 2'b01;
    tick("follow_left", ex(1, 2, 1, 0, 0));
    cam_dir = 2'b10;
    tick("follow_right", ex(1, 2, 2, 0, 0));
    cam_dir = 2'b11;
    tick("follow_fwd2", ex(1, 2, 3, 3, 0));
    target_seen = 1'b0;
    tick("lost_enter", ex(1, 3, 0, 0, 1));
    repeat (498) tick("lost_hold", ex(1, 3, 0, 0, 0));
    target_seen = 1'b1;
    tick("reacquire_500", ex(1, 2, 3, 3, 1));
    target_seen = 1'b0;
    tick("lost2_enter", ex(1, 3, 0, 0, 1));
    repeat (999) tick("lost2_hold", ex(1, 3, 0, 0, 0));
    tick("lost_to_search", ex(1, 0, 2, 0, 1));
    target_seen = 1'b1;
    ir(8'h10, "idle_priority", ex(0, 4, 0, 0, 1));
    target_seen = 1'b0;
    tick("idle_hold", ex(0, 4, 0, 0, 0));
    ir(8'h13, "ir_on", ex(2, 4, 0, 0, 1));
    tick("ir_hold", ex(2, 4, 0, 0, 0));
    repeat (5) ir(8'h01, "ir_up", ex(2, 4, 0, 0, 0));
    ir(8'h02, "ir_fwd_sat", ex(2, 4, 3, 3, 0));
    ir(8'h03, "ir_down", ex(2, 4, 3, 2, 0));
    ir(8'h01, "ir_up_again", ex(2, 4, 3, 3, 0));
    ir(8'h02, "ir_fwd_reload", ex(2, 4, 3, 3, 0));
    repeat (4999) tick("ir_fwd_hold", ex(2, 4, 3, 3, 0));
    tick("ir_timeout", ex(2, 4, 0, 0, 0));
    ir(8'h04, "ir_left", ex(2, 4, 1, 0, 0));
    ir(8'h05, "ir_stop", ex(2, 4, 0, 0, 0));
    ir(8'h13, "ir_noop", ex(2, 4, 0, 0, 0));
    ir(8'h0F, "cam_again", ex(1, 0, 2, 0, 1));
    ir(8'h13, "ir_reenter", ex(2, 4, 0, 0, 1));
    ir(8'h02, "ir_fwd_spd0", ex(2, 4, 3, 0, 0));
    ir(8'h0F, "cam_third", ex(1, 0, 2, 0, 1));
    target_seen = 1'b1;
    tick("acq_r", ex(1, 1, 0, 0, 1));
    repeat (6) tick("acq_r_hold", ex(1, 1, 0, 0, 0));
    tick("follow_r", ex(1, 2, 3, 3, 1));
    #2 reset_n = 1'b0;
    #1 check("reset_mid_follow", ex(0, 4, 0, 0, 0));
    #3 reset_n = 1'b1;
    target_seen = 1'b0;
    tick("after_reset", ex(0, 4, 0, 0, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end
endmodule
